// File: rtl/tff_bank_counter.sv
// tff_bank_counter: WIDTH-bit bank of T flip-flops.
// mode=1 toggles each bit independently under t.
// mode=0 runs a modulo-MOD up/down counter whose toggle enables come from the
// carry/borrow prefix chains.
// There is a parallel load, a combinational terminal-count decode and a
// registered wrap pulse.
// Optional macro TFF_BANK_SAT_EN makes count mode saturate instead of wrap.
// With the macro defined, wrap is held at 0.
module tff_bank_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             up,
   input  logic [WIDTH-1:0] t,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   // Largest in-range count value.
   // The modulus may equal 2**WIDTH, so it is never formed at WIDTH bits itself.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;

   // Prefix chains: bit i toggles on an increment when all lower bits are 1.
   // Bit i toggles on a decrement when all lower bits are 0.
   logic [WIDTH-1:0] ones_below;
   logic [WIDTH-1:0] zeros_below;
   logic [WIDTH-1:0] count_tgl;
   logic             at_max;
   logic             at_zero;

   assign ones_below[0]  = 1'b1;
   assign zeros_below[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_chain
         assign ones_below[gi]  = ones_below[gi-1]  &  q_q[gi-1];
         assign zeros_below[gi] = zeros_below[gi-1] & ~q_q[gi-1];
      end
   endgenerate

   assign count_tgl = up ? ones_below : zeros_below;

   // A value above MAX_VAL is only reachable through toggle mode.
   // Counting up from such a value is treated like counting up from MAX_VAL.
   assign at_max  = (q_q >= MAX_VAL);
   assign at_zero = (q_q == '0);

   // Next-state selection: load beats enable, enable beats hold.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (load) begin
         q_d = (d > MAX_VAL) ? MAX_VAL : d;
      end else if (en) begin
         if (mode) begin
            q_d = q_q ^ t;
         end else if (up) begin
            if (at_max) begin
`ifdef TFF_BANK_SAT_EN
               q_d    = MAX_VAL;
`else
               q_d    = '0;
               wrap_d = 1'b1;
`endif
            end else begin
               q_d = q_q ^ count_tgl;
            end
         end else begin
            if (at_zero) begin
`ifdef TFF_BANK_SAT_EN
               q_d    = q_q;
`else
               q_d    = MAX_VAL;
               wrap_d = 1'b1;
`endif
            end else begin
               q_d = q_q ^ count_tgl;
            end
         end
      end
   end

   // State register.
   // Reset clears the bank and the wrap pulse without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   // Terminal count follows mode and direction within the same cycle.
   assign tc   = ~mode & ((up & (q_q == MAX_VAL)) | (~up & at_zero));
   assign q    = q_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// tb_tff_bank_counter: directed and pseudo-random stimulus for tff_bank_counter.
// The design is built with WIDTH=4 and MOD=10.
// An arithmetic reference model is compared against the design on every falling edge.
// Hand-computed literal checks pin the reference model itself.
// If TFF_BANK_SAT_EN is defined, the bench expects saturating count behaviour.
module tb_tff_bank_counter;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;
`ifdef TFF_BANK_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             mode;
   logic             up;
   logic [WIDTH-1:0] t;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   tff_bank_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .mode (mode),
      .up   (up),
      .t    (t),
      .load (load),
      .d    (d),
      .q    (q),
      .tc   (tc),
      .wrap (wrap)
   );

   always #5 clk = ~clk;

   // Reference model: the counter value is an integer, updated by the rules directly.
   int m_q;
   bit m_wrap;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q    <= 0;
         m_wrap <= 1'b0;
      end else if (load) begin
         m_q    <= (int'(d) < MOD) ? int'(d) : MOD - 1;
         m_wrap <= 1'b0;
      end else if (en && mode) begin
         m_q    <= m_q ^ int'(t);
         m_wrap <= 1'b0;
      end else if (en && up) begin
         if (m_q >= MOD - 1) begin
            m_q    <= SAT ? MOD - 1 : 0;
            m_wrap <= !SAT;
         end else begin
            m_q    <= m_q + 1;
            m_wrap <= 1'b0;
         end
      end else if (en) begin
         if (m_q == 0) begin
            m_q    <= SAT ? 0 : MOD - 1;
            m_wrap <= !SAT;
         end else begin
            m_q    <= m_q - 1;
            m_wrap <= 1'b0;
         end
      end else begin
         m_wrap <= 1'b0;
      end
   end

   function automatic bit model_tc();
      return !mode && ((up && m_q == MOD - 1) || (!up && m_q == 0));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_q",    32'(q),    32'(m_q));
         chk("cyc_tc",   32'(tc),   32'(model_tc()));
         chk("cyc_wrap", 32'(wrap), 32'(m_wrap));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int e;

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; up = 1'b1;
      t = '0; load = 1'b0; d = '0;
      repeat (2) tick();
      check_en = 1'b1;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_tc", 32'(tc), 32'd0);

      // Count to 7, then assert reset between edges.
      rst_n = 1'b1; en = 1'b1;
      repeat (7) tick();
      chk("pre_rst_q", 32'(q), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("async_q", 32'(q), 32'd0);
      chk("async_wrap", 32'(wrap), 32'd0);
      tick();
      chk("rst_hold_q", 32'(q), 32'd0);
      rst_n = 1'b1;

      // Count up for 12 edges after reset release.
      for (int k = 0; k < 12; k++) begin
         tick();
         e = SAT ? ((k + 1 > 9) ? 9 : k + 1) : (k + 1) % 10;
         chk("up_q", 32'(q), 32'(e));
         chk("up_wrap", 32'(wrap), 32'((!SAT && k == 9) ? 1 : 0));
         chk("up_tc", 32'(tc), 32'((e == 9) ? 1 : 0));
         $display("count up step %0d: q=%0d tc=%0b wrap=%0b", k, q, tc, wrap);
      end

      // Load 0, then count down through the wrap, then hold.
      load = 1'b1; d = 4'h0;
      tick();
      chk("load0_q", 32'(q), 32'd0);
      load = 1'b0; up = 1'b0;
      #1 chk("tc_down_zero", 32'(tc), 32'd1);
      tick();
      chk("down1_q", 32'(q), 32'(SAT ? 0 : 9));
      chk("down1_wrap", 32'(wrap), 32'(SAT ? 0 : 1));
      tick();
      chk("down2_q", 32'(q), 32'(SAT ? 0 : 8));
      chk("down2_wrap", 32'(wrap), 32'd0);
      tick();
      chk("down3_q", 32'(q), 32'(SAT ? 0 : 7));
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_q", 32'(q), 32'(SAT ? 0 : 7));
         chk("hold_wrap", 32'(wrap), 32'd0);
         $display("hold step %0d: q=%0d wrap=%0b", k, q, wrap);
      end

      // Load clamps above MOD-1 and takes priority over counting.
      load = 1'b1; d = 4'hC;
      tick();
      chk("load_clamp_q", 32'(q), 32'd9);
      d = 4'h3; en = 1'b1; up = 1'b1;
      tick();
      chk("load_prio_q", 32'(q), 32'd3);

      // Toggle mode: MOD is not applied.
      d = 4'h0;
      tick();
      load = 1'b0; mode = 1'b1; t = 4'b0101;
      tick();
      chk("tgl1_q", 32'(q), 32'd5);
      tick();
      chk("tgl2_q", 32'(q), 32'd0);
      t = 4'b1111;
      tick();
      chk("tgl3_q", 32'(q), 32'd15);
      chk("tgl3_tc", 32'(tc), 32'd0);

      // Out-of-range value: down decrements normally, up wraps.
      mode = 1'b0; up = 1'b0;
      #1 chk("oor_tc", 32'(tc), 32'd0);
      tick();
      chk("oor_down_q", 32'(q), 32'd14);
      up = 1'b1;
      tick();
      chk("oor_up_q", 32'(q), 32'(SAT ? 9 : 0));
      chk("oor_up_wrap", 32'(wrap), 32'(SAT ? 0 : 1));

      // Count down from 2 for four edges.
      load = 1'b1; d = 4'h2;
      tick();
      load = 1'b0; up = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         case (k)
            0: e = 1;
            1: e = 0;
            2: e = SAT ? 0 : 9;
            default: e = SAT ? 0 : 8;
         endcase
         chk("dn2_q", 32'(q), 32'(e));
         $display("count down step %0d: q=%0d wrap=%0b", k, q, wrap);
      end

      // Pseudo-random mix, checked only against the model.
      // The mix includes an occasional short reset pulse between edges.
      for (int k = 0; k < 80; k++) begin
         en   = ($urandom_range(0, 3) != 0);
         mode = ($urandom_range(0, 3) == 0);
         up   = $urandom_range(0, 1) == 1;
         t    = WIDTH'($urandom_range(0, 15));
         load = ($urandom_range(0, 9) == 0);
         d    = WIDTH'($urandom_range(0, 15));
         if (k == 40) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         tick();
         $display("random step %0d: q=%0d tc=%0b wrap=%0b", k, q, tc, wrap);
      end

      @(negedge clk);
      #1;
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
